// File: rtl/exmem_memwb_pipe_pkg.sv
// ---------------------------------------------------------------------------
// exmem_memwb_pipe_pkg
//   Shared widths, stage field bundles and bubble constants for the EX/MEM and
//   MEM/WB pipeline latches of the 5-stage core.
//   Contents:
//     XLEN, REG_AW            datapath / register-address widths
//     exmem_t, memwb_t        packed field bundles held by each latch
//     BUBBLE_EXMEM/MEMWB      all-zero "no instruction" values
//     wbSelect()              write-back data select (load data vs ALU result)
// ---------------------------------------------------------------------------
package exmem_memwb_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Contents of the EX/MEM latch. valid marks a real instruction; it is
    // kept internally so the retire counter and MEM/WB bubble logic can use it.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memtoreg;
        logic              memread;
        logic              memwrite;
        logic [XLEN-1:0]   aluResult;
        logic [XLEN-1:0]   storeData;
    } exmem_t;

    // Contents of the MEM/WB latch.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic [XLEN-1:0]   wbData;
    } memwb_t;

    // A bubble is the all-zero bundle: no write enable, no memory strobe,
    // destination x0 and zero data, so nothing downstream can act on it.
    localparam exmem_t BUBBLE_EXMEM = '0;
    localparam memwb_t BUBBLE_MEMWB = '0;

    // Loads take the memory read data, everything else the ALU result.
    function automatic logic [XLEN-1:0] wbSelect(input exmem_t s,
                                                 input logic [XLEN-1:0] rdata);
        return s.memtoreg ? rdata : s.aluResult;
    endfunction

endpackage

// File: rtl/exmem_memwb_pipe_if.sv
// ---------------------------------------------------------------------------
// exmem_memwb_pipe_if
//   Bundle of the signals between the EX stage / data memory (master side)
//   and the back-end pipeline latches (slave side).
//   master: drives stall, flush, ex_* fields and mem_rdata; observes the
//           EXMEM_* / MEMWB_* latch outputs.
//   slave : the pipeline block, the reverse directions.
// ---------------------------------------------------------------------------
interface exmem_memwb_pipe_if;
    import exmem_memwb_pipe_pkg::*;

    // control
    logic              stall;
    logic              flush;

    // EX stage instruction
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memtoreg;
    logic              ex_memread;
    logic              ex_memwrite;
    logic [XLEN-1:0]   ex_alu_result;
    logic [XLEN-1:0]   ex_store_data;

    // data memory read data for the EX/MEM address
    logic [XLEN-1:0]   mem_rdata;

    // EX/MEM latch outputs
    logic [REG_AW-1:0] EXMEM_Rd;
    logic              EXMEM_RegWrite;
    logic [XLEN-1:0]   EXMEM_ALUResult;
    logic              EXMEM_MemRead;
    logic              EXMEM_MemWrite;
    logic [XLEN-1:0]   EXMEM_StoreData;

    // MEM/WB latch outputs
    logic [REG_AW-1:0] MEMWB_Rd;
    logic              MEMWB_RegWrite;
    logic [XLEN-1:0]   MEMWB_WBData;

    modport master (
        output stall, flush,
        output ex_valid, ex_rd, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
        output ex_alu_result, ex_store_data,
        output mem_rdata,
        input  EXMEM_Rd, EXMEM_RegWrite, EXMEM_ALUResult, EXMEM_MemRead,
        input  EXMEM_MemWrite, EXMEM_StoreData,
        input  MEMWB_Rd, MEMWB_RegWrite, MEMWB_WBData
    );

    modport slave (
        input  stall, flush,
        input  ex_valid, ex_rd, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
        input  ex_alu_result, ex_store_data,
        input  mem_rdata,
        output EXMEM_Rd, EXMEM_RegWrite, EXMEM_ALUResult, EXMEM_MemRead,
        output EXMEM_MemWrite, EXMEM_StoreData,
        output MEMWB_Rd, MEMWB_RegWrite, MEMWB_WBData
    );

endinterface

// File: rtl/exmem_memwb_pipe_reg.sv
// ---------------------------------------------------------------------------
// exmem_memwb_pipe_reg
//   Generic pipeline latch: asynchronous active-low reset, hold, and
//   synchronous clear to a bubble value.
//   Ports:
//     clk, rst_n  clock, async active-low reset (q <= CLR_VAL)
//     en          1 = update this edge, 0 = hold (stall)
//     clr         with en=1, load CLR_VAL instead of d (bubble insert)
//     d, q        W-bit data in / registered data out
//   A hold takes priority over a clear, so a kill requested during a stall
//   does nothing until the stall lifts.
// ---------------------------------------------------------------------------
module exmem_memwb_pipe_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= clr ? CLR_VAL : d;
        end
    end

endmodule

// File: rtl/exmem_memwb_pipe.sv
// ---------------------------------------------------------------------------
// exmem_memwb_pipe
//   Back-end pipeline of the 5-stage core: EX/MEM and MEM/WB latches, the
//   write-back data select, and a retired-instruction counter.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     bus (slave)    stall/flush, ex_* instruction fields, mem_rdata in;
//                    EXMEM_* and MEMWB_* latch values out (to forwarding
//                    unit, data memory and register file)
//     retired_count  instructions committed into MEM/WB, wraps at 2^CNT_W
//   All outputs come straight from flops; there is no input-to-output path.
// ---------------------------------------------------------------------------
module exmem_memwb_pipe
    import exmem_memwb_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    exmem_memwb_pipe_if.slave   bus,
    output logic [CNT_W-1:0]    retired_count
);

    exmem_t exmemD, exmemQ;
    memwb_t memwbD, memwbQ;
    logic   advance;
    logic   exmemClr;
    logic   memwbClr;

    // A stall freezes both latches and the counter together.
    assign advance = !bus.stall;

    // ---------------- EX/MEM capture ----------------
    always_comb begin
        exmemD           = BUBBLE_EXMEM;
        exmemD.valid     = 1'b1;
        exmemD.rd        = bus.ex_rd;
        // Writes to x0 are dropped here so no later stage or forwarding
        // consumer ever sees an enabled write to the zero register.
        exmemD.regwrite  = bus.ex_regwrite && (bus.ex_rd != '0);
        exmemD.memtoreg  = bus.ex_memtoreg;
        exmemD.memread   = bus.ex_memread;
        exmemD.memwrite  = bus.ex_memwrite;
        exmemD.aluResult = bus.ex_alu_result;
        exmemD.storeData = bus.ex_store_data;
    end

    assign exmemClr = bus.flush || !bus.ex_valid;

    exmem_memwb_pipe_reg #(
        .W       ($bits(exmem_t)),
        .CLR_VAL (BUBBLE_EXMEM)
    ) u_exmem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .clr   (exmemClr),
        .d     (exmemD),
        .q     (exmemQ)
    );

    // ---------------- MEM/WB capture ----------------
    always_comb begin
        memwbD          = BUBBLE_MEMWB;
        memwbD.valid    = exmemQ.valid;
        memwbD.rd       = exmemQ.rd;
        memwbD.regwrite = exmemQ.regwrite;
        memwbD.wbData   = wbSelect(exmemQ, bus.mem_rdata);
    end

    // A bubble in EX/MEM becomes a clean bubble in MEM/WB, independent of
    // whatever the memory happens to return for address 0.
    assign memwbClr = !exmemQ.valid;

    exmem_memwb_pipe_reg #(
        .W       ($bits(memwb_t)),
        .CLR_VAL (BUBBLE_MEMWB)
    ) u_memwb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance),
        .clr   (memwbClr),
        .d     (memwbD),
        .q     (memwbQ)
    );

    // ---------------- retire counter ----------------
    // Counts an instruction as it moves from EX/MEM into MEM/WB; natural
    // modulo-2^CNT_W wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (advance && exmemQ.valid) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    // ---------------- outputs ----------------
    assign bus.EXMEM_Rd        = exmemQ.rd;
    assign bus.EXMEM_RegWrite  = exmemQ.regwrite;
    assign bus.EXMEM_ALUResult = exmemQ.aluResult;
    assign bus.EXMEM_MemRead   = exmemQ.memread;
    assign bus.EXMEM_MemWrite  = exmemQ.memwrite;
    assign bus.EXMEM_StoreData = exmemQ.storeData;

    assign bus.MEMWB_Rd        = memwbQ.rd;
    // regwrite is already zero for bubbles; gating with valid keeps the
    // enable safe even if the bubble encoding ever changes.
    assign bus.MEMWB_RegWrite  = memwbQ.valid && memwbQ.regwrite;
    assign bus.MEMWB_WBData    = memwbQ.wbData;

endmodule
